// File: rtl/md_defs.sv
// Shared encodings and sizing for the EX-stage multiply/divide unit.
package md_defs;

  localparam int CNT_W = 4;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Operations that occupy the unit for multiple cycles.
  function automatic logic is_long_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational product/quotient datapath; results are latched into the
// pending registers at the issue edge.
module md_arith
  import md_defs::*;
(
  input  logic [3:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] cur_hi,
  input  logic [31:0] cur_lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] b_nz;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic        b_zero;

  assign prod_u = {32'd0, a} * {32'd0, b};
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};

  assign b_zero = (b == 32'd0);
  assign b_nz   = b_zero ? 32'd1 : b;

  // Signed divide via magnitudes keeps 0x80000000 / -1 well defined.
  assign a_mag = a[31] ? (32'd0 - a) : a;
  assign b_mag = b_nz[31] ? (32'd0 - b_nz) : b_nz;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign quo_s = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
  assign rem_s = a[31] ? (32'd0 - r_mag) : r_mag;

  assign quo_u = a / b_nz;
  assign rem_u = a % b_nz;

  always_comb begin
    res_hi = cur_hi;
    res_lo = cur_lo;
    case (md_op)
      MD_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MD_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MD_DIV: begin
        if (!b_zero) begin
          res_hi = rem_s;
          res_lo = quo_s;
        end
      end
      MD_DIVU: begin
        if (!b_zero) begin
          res_hi = rem_u;
          res_lo = quo_u;
        end
      end
      default: begin
        res_hi = cur_hi;
        res_lo = cur_lo;
      end
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO owner for the EX stage: accepts mult/div, holds busy for a fixed
// latency with a down-counter, then commits the pending result.
module mult_div_unit
  import md_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] count;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             accept;

  md_arith u_arith (
    .md_op  (md_op),
    .a      (A),
    .b      (B),
    .cur_hi (hi),
    .cur_lo (lo),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  // Gated by reset so start reads low while the unit is held in reset.
  assign accept = reset & req & ~busy & is_long_op(md_op);
  assign start  = accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      count   <= '0;
      busy    <= 1'b0;
    end else if (accept) begin
      pend_hi <= res_hi;
      pend_lo <= res_lo;
      count   <= is_div_op(md_op) ? DIV_LOAD : MULT_LOAD;
      busy    <= 1'b1;
    end else if (busy) begin
      if (count == CNT_W'(1)) begin
        hi    <= pend_hi;
        lo    <= pend_lo;
        count <= '0;
        busy  <= 1'b0;
      end else begin
        count <= count - CNT_W'(1);
      end
    end else if (req) begin
      if (md_op == MD_MTHI) hi <= A;
      if (md_op == MD_MTLO) lo <= A;
    end
  end

  always_comb begin
    md_out = 32'd0;
    if (md_op == MD_MFHI) md_out = hi;
    else if (md_op == MD_MFLO) md_out = lo;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table plus corner sequences.
module tb_mult_div_unit;
  import md_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [3:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        start;
  logic        busy;
  logic [31:0] md_out;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
    bit          probe;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  vec_t vecs[9];
  res_t sb[$];
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  mult_div_unit dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .md_op  (md_op),
    .A      (A),
    .B      (B),
    .start  (start),
    .busy   (busy),
    .md_out (md_out),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req   = 1'b0;
    md_op = MD_NONE;
    A     = 32'd0;
    B     = 32'd0;
  endtask

  // Called at a negedge; drives a long op and lets the issue edge pass.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req   = 1'b1;
    md_op = op;
    A     = a;
    B     = b;
    #1;
    chk("start_on_issue", {31'd0, start}, 32'd1);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  // Counts busy cycles at negedges; returns at the first negedge with busy=0.
  task automatic wait_done(input int n_exp, input bit probe);
    int   cnt;
    res_t exp;
    cnt = 0;
    if (probe) begin
      req   = 1'b1;
      md_op = MD_MFLO;
      A     = 32'hDEAD_BEEF;
    end
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      if (probe) begin
        chk("stall_start_low", {31'd0, start}, 32'd0);
        chk("stall_hi_held", hi, model_hi);
        chk("stall_lo_held", lo, model_lo);
        chk("stall_md_out_stale", md_out, model_lo);
      end
    end
    chk("busy_cycles", cnt, n_exp);
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      exp = sb.pop_front();
      chk("result_hi", hi, exp.hi);
      chk("result_lo", lo, exp.lo);
      model_hi = exp.hi;
      model_lo = exp.lo;
      if (probe) begin
        #1;
        chk("mflo_after_done", md_out, exp.lo);
      end
    end
    if (probe) idle_inputs();
  endtask

  initial begin
    vecs[0] = '{MD_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5,  1'b0};
    vecs[1] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5,  1'b1};
    vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0};
    vecs[3] = '{MD_DIVU,  32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, 10, 1'b0};
    vecs[4] = '{MD_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5,  1'b0};
    vecs[5] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5,  1'b0};
    vecs[6] = '{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10, 1'b0};
    vecs[7] = '{MD_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 10, 1'b0};
    vecs[8] = '{MD_MULTU, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 5,  1'b1};

    // Reset state, with a MULT request held to confirm start stays low.
    reset = 1'b0;
    req   = 1'b1;
    md_op = MD_MULT;
    A     = 32'd2;
    B     = 32'd2;
    #2;
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    md_op = MD_MFHI;
    #1;
    chk("rst_md_out", md_out, 32'd0);
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      sb.push_back('{vecs[i].hi, vecs[i].lo});
      wait_done(vecs[i].cycles, vecs[i].probe);
    end

    // MTHI / MTLO, then divide by zero keeps them.
    req = 1'b1; md_op = MD_MTHI; A = 32'h1234_5678;
    #1;
    chk("mthi_start_low", {31'd0, start}, 32'd0);
    @(posedge clk); #1;
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy_low", {31'd0, busy}, 32'd0);
    md_op = MD_MTLO; A = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    chk("mtlo_lo", lo, 32'h9ABC_DEF0);
    chk("mtlo_hi_kept", hi, 32'h1234_5678);
    req = 1'b0; md_op = MD_MTLO; A = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("mtlo_noreq_lo", lo, 32'h9ABC_DEF0);
    idle_inputs();
    model_hi = 32'h1234_5678;
    model_lo = 32'h9ABC_DEF0;
    @(negedge clk);
    issue(MD_DIV, 32'h0000_0055, 32'd0);
    sb.push_back('{32'h1234_5678, 32'h9ABC_DEF0});
    wait_done(10, 1'b0);
    req = 1'b1; md_op = MD_MFHI;
    #1;
    chk("mfhi_md_out", md_out, 32'h1234_5678);
    md_op = MD_MFLO;
    #1;
    chk("mflo_md_out", md_out, 32'h9ABC_DEF0);
    idle_inputs();
    @(negedge clk);

    // Overflowing DIV, then a MULT accepted in the cycle busy falls.
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    sb.push_back('{32'h0000_0000, 32'h8000_0000});
    wait_done(10, 1'b0);
    issue(MD_MULT, 32'd2, 32'd2);
    sb.push_back('{32'h0000_0000, 32'h0000_0004});
    wait_done(5, 1'b0);

    // Reset in the middle of a DIV aborts it.
    issue(MD_DIVU, 32'h0000_0063, 32'h0000_0003);
    repeat (4) @(negedge clk);
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    chk("abort_busy_after", {31'd0, busy}, 32'd0);
    chk("abort_hi_after", hi, 32'd0);
    chk("abort_lo_after", lo, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- EX-stage multiply/divide unit; runs in parallel with the ALU on the same rs/rt operands.
- Owns the HI/LO registers and implements mult, multu, div, divu, mthi, mtlo, mfhi and mflo.
- Multi-cycle latency is modelled with a down-counter.
- Busy/start feed the hazard unit, which stalls any HI/LO-touching instruction in ID.

Parameters:
- MULT_CYCLES, 5, cycles busy after a mult/multu is accepted (must be >=1).
- DIV_CYCLES, 10, cycles busy after a div/divu is accepted (must be >=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- req  in  1  a real (non-bubble) instruction is in EX this cycle.
- md_op  in  4  decoded operation, encodings from md_defs.
- A  in  32  forwarded rs value.
- B  in  32  forwarded rt value.
- start  out  1  combinational; high when a mult/div is accepted this cycle.
- busy  out  1  registered; high while a mult/div is in flight.
- md_out  out  32  combinational; HI for MFHI, LO for MFLO, 0 otherwise.
- hi  out  32  architectural HI register.
- lo  out  32  architectural LO register.

Behaviour:
Reset:
- reset=0 asynchronously forces HI=0, LO=0, counter=0, busy=0, pend_hi=0, pend_lo=0.
- Outputs follow combinationally: start=0, md_out=0.
- A reset asserted mid-operation aborts the pending result; HI/LO never receive it.

Acceptance:
- accept = req & !busy & md_op in {MULT, MULTU, DIV, DIVU}.
- start = accept.
- Any md_op with req=1 while busy=1 has no effect. The hazard unit guarantees this never happens; the bench asserts it.

Issue edge (accept=1):
- pend_hi/pend_lo <= result computed from A and B in the same cycle.
- counter <= MULT_CYCLES or DIV_CYCLES; busy <= 1.

In flight:
- Each later edge with counter>1 decrements the counter.
- At the edge where counter==1: HI<=pend_hi, LO<=pend_lo, counter<=0, busy<=0.
- busy is therefore high for exactly N cycles after the issue edge.
- New HI/LO are visible on the first cycle busy=0, and a new mult/div may be accepted in that same cycle.

Arithmetic:
- MULT: {HI,LO} = signed 32x32 -> 64.
- MULTU: {HI,LO} = unsigned 32x32 -> 64.
- DIV: LO = quotient truncated toward zero; HI = remainder, which takes the dividend's sign.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, no trap.
- DIVU: unsigned quotient/remainder.
- Divide by zero (DIV or DIVU): runs the full DIV_CYCLES, then HI/LO keep their previous values (pend regs loaded from current HI/LO).

MTHI/MTLO (req=1, busy=0):
- HI<=A (MTHI) or LO<=A (MTLO) at the next edge, single cycle.
- Does not set busy or start.

MFHI/MFLO:
- md_out reflects the HI/LO register value combinationally, with no internal bypass.
- While busy, md_out shows stale values; the stall makes this unobservable.

Other:
- NONE, unknown md_op, or req=0 leave all state unchanged; start=0.
- The unit takes no stall/flush input. An accepted operation always completes, even if the issuing instruction is later squashed (P6 has no exceptions).

Decomposition:
Package md_defs holds:
- md_op localparams: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8.
- MULT_CYCLES/DIV_CYCLES defaults.
- Counter width (4 bits).

One combinational sub-module, md_arith:
- Inputs: md_op, A, B, cur_hi, cur_lo.
- Outputs: res_hi, res_lo; includes the signed/unsigned and divide-by-zero handling.
- The top level holds the counter, busy, pend regs, HI/LO and the output mux.

Test Plan:
1. Reset, then MULT A=0xFFFFFFFE(-2) B=3 -> start=1 that cycle; busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
2. MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001. During cycles 1-5, md_op=MFLO with req=1 leaves state unchanged (assert).
3. DIV A=-7 (0xFFFFFFF9) B=2 -> busy 10 cycles; LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1). DIVU same operands -> LO=0x7FFFFFFC, HI=1.
4. MTHI A=0x12345678, then MTLO A=0x9ABCDEF0, then DIV B=0 -> busy 10 cycles; HI/LO remain 0x12345678/0x9ABCDEF0. MFHI/MFLO return these values on md_out.
5. DIV A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0. A MULT with A=B=2 issued the same cycle busy falls is accepted (start=1) -> LO=4 after 5 further cycles.
6. Start DIV, drive reset=0 at busy cycle 4 between clock edges -> HI, LO, busy clear immediately. After release, HI=LO=0 and the aborted result never appears.
